// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: runs one ack-handshaked read or write on the external memory port per request.
// Optional ACCESS timeout abort is compiled in when MEMSEQ_TIMEOUT_EN is defined.
module mem_access_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              read_req,
  input  logic              write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q,  timeout_d;
  logic       err_q,      err_d;
`else
  logic timeout_unused_s;
  assign timeout_unused_s = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    done_d      = 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (read_req || write_req) begin
          state_d     = ST_ACCESS;
          mem_addr_d  = address_bus;
          mem_wdata_d = wdata_in;
          mem_we_d    = write_req;
          mem_req_d   = 1'b1;
`ifdef MEMSEQ_TIMEOUT_EN
          wait_cnt_d  = 8'd0;
          timeout_d   = 1'b0;
`endif
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        // Ack wins over a timeout that would fire on the same edge.
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`else
        else begin
          mem_req_d = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
`ifdef MEMSEQ_TIMEOUT_EN
        err_d   = timeout_q;
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    // Busy stays up until the done pulse has been presented to the control FSM.
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MEMSEQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MEMSEQ_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios plus randomized transactions
// compared against a transaction-level model of latency, bus contents and held read data.
module tb_mem_access_sequencer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address_bus;
  logic [DW-1:0] wdata_in;
  logic          read_req, write_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_rdata, rdata;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rdata_model;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .address_bus(address_bus), .wdata_in(wdata_in),
    .read_req(read_req), .write_req(write_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  // One request pulse; ack after 'waits' wait cycles (never if waits < 0). Observes windows after each edge.
  task automatic drive_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rdv,
                           output int req_cycles, output int done_at, output int done_width,
                           output logic err_seen, output logic we_seen, output logic [AW-1:0] addr_seen,
                           output logic [DW-1:0] wdata_seen, output logic stable, output logic busy_ok);
    read_req = rd; write_req = wr; address_bus = addr; wdata_in = wd;
    req_cycles = 0; done_at = -1; done_width = 0; err_seen = 1'b0; stable = 1'b1; busy_ok = 1'b1;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      @(negedge clk);
      read_req = 1'b0; write_req = 1'b0; address_bus = AW'($urandom); mem_ack = 1'b0;
      if (done_at >= 0 && !done) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (done === 1'b1) begin
        if (done_at < 0) done_at = k;
        done_width++;
        if (err === 1'b1) err_seen = 1'b1;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end else if (err !== 1'b0) begin
        err_seen = 1'b1;
      end
      if (mem_req === 1'b1) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (req_cycles == 0) begin
          we_seen = mem_we; addr_seen = mem_addr; wdata_seen = mem_wdata;
        end else if (mem_we !== we_seen || mem_addr !== addr_seen || mem_wdata !== wdata_seen) begin
          stable = 1'b0;
        end
        req_cycles++;
        if (waits >= 0 && req_cycles == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = rdv;
        end else begin
          mem_rdata = DW'($urandom);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read_req = 1'b0; write_req = 1'b0; mem_ack = 1'b0;
    address_bus = '0; wdata_in = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_addr, mem_wdata, rdata, mem_req, mem_we, busy, done, err} !== 53'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {mem_addr, mem_wdata, rdata, mem_req, mem_we, busy, done, err});
    end
    reset_n = 1'b1; rdata_model = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy=%b mem_req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    logic bad;
    write_req = 1'b1; address_bus = 16'h0040; wdata_in = DW'($urandom);
    @(negedge clk);
    write_req = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b1) begin
      errors++; $display("FAIL mid_reset_access: mem_req=%b addr=%h we=%b expected 1 0040 1", mem_req, mem_addr, mem_we);
    end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async_req: mem_req=%b expected 0", mem_req);
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata, mem_we, busy, done, err} !== 52'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {mem_addr, mem_wdata, rdata, mem_we, busy, done, err});
    end
    @(negedge clk);
    reset_n = 1'b1; rdata_model = '0; bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL mid_reset_no_done: activity after reset=%b expected 0", bad);
    end
  endtask

  task automatic test_zero_wait_read();
    int rc, da, dw; logic es, we, st, bo; logic [AW-1:0] a; logic [DW-1:0] w;
    drive_txn(1'b1, 1'b0, 16'h1234, DW'($urandom), 0, 16'hBEEF, rc, da, dw, es, we, a, w, st, bo);
    rdata_model = 16'hBEEF;
    checks++; if (rc !== 1) begin errors++; $display("FAIL zw_req_cycles: got %0d expected 1", rc); end
    checks++; if (a !== 16'h1234 || we !== 1'b0) begin errors++; $display("FAIL zw_addr_we: got %h/%b expected 1234/0", a, we); end
    checks++; if (da !== 2 || dw !== 1) begin errors++; $display("FAIL zw_done: at %0d width %0d expected 2 1", da, dw); end
    checks++; if (rdata !== rdata_model) begin errors++; $display("FAIL zw_rdata: got %h expected %h", rdata, rdata_model); end
    checks++; if (es !== 1'b0 || bo !== 1'b1) begin errors++; $display("FAIL zw_err_busy: err=%b busy_ok=%b expected 0 1", es, bo); end
  endtask

  task automatic test_waited_write();
    int rc, da, dw; logic es, we, st, bo; logic [AW-1:0] a; logic [DW-1:0] w;
    drive_txn(1'b0, 1'b1, 16'h00FF, 16'hA5A5, 3, DW'($urandom), rc, da, dw, es, we, a, w, st, bo);
    checks++; if (we !== 1'b1 || w !== 16'hA5A5 || a !== 16'h00FF) begin errors++; $display("FAIL ww_bus: we=%b data=%h addr=%h expected 1 a5a5 00ff", we, w, a); end
    checks++; if (rc !== 4 || st !== 1'b1) begin errors++; $display("FAIL ww_req_cycles: got %0d stable=%b expected 4 1", rc, st); end
    checks++; if (da !== 5 || dw !== 1) begin errors++; $display("FAIL ww_done: at %0d width %0d expected 5 1", da, dw); end
    checks++; if (rdata !== rdata_model) begin errors++; $display("FAIL ww_rdata_held: got %h expected %h", rdata, rdata_model); end
  endtask

  task automatic test_simultaneous();
    int rc, da, dw; logic es, we, st, bo; logic [AW-1:0] a; logic [DW-1:0] w;
    drive_txn(1'b1, 1'b1, 16'h5A5A, 16'h3C3C, 0, 16'h7777, rc, da, dw, es, we, a, w, st, bo);
    checks++; if (we !== 1'b1 || w !== 16'h3C3C) begin errors++; $display("FAIL sim_write_wins: we=%b data=%h expected 1 3c3c", we, w); end
    checks++; if (rdata !== rdata_model || da !== 2) begin errors++; $display("FAIL sim_rdata_done: rdata=%h done_at=%0d expected %h 2", rdata, da, rdata_model); end
  endtask

  task automatic test_ignore_during_access();
    int reqs = 0, dones = 0; logic addr_ok = 1'b1;
    write_req = 1'b1; address_bus = 16'hC0DE; wdata_in = DW'($urandom);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      write_req = 1'b0; mem_ack = 1'b0;
      read_req = (k <= 3); address_bus = AW'($urandom);
      if (mem_req === 1'b1) begin
        reqs++;
        if (mem_addr !== 16'hC0DE || mem_we !== 1'b1) addr_ok = 1'b0;
        if (reqs == 3) begin mem_ack = 1'b1; mem_rdata = DW'($urandom); end
      end
      if (done === 1'b1) dones++;
    end
    read_req = 1'b0; mem_ack = 1'b0;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL ign_addr_latched: ok=%b expected 1", addr_ok); end
    checks++; if (reqs !== 3 || dones !== 1) begin errors++; $display("FAIL ign_no_queue: req cycles %0d dones %0d expected 3 1", reqs, dones); end
    checks++; if (rdata !== rdata_model) begin errors++; $display("FAIL ign_rdata: got %h expected %h", rdata, rdata_model); end
  endtask

  task automatic test_back_to_back();
    int rises[$]; int dts[$]; logic [DW-1:0] rds[$]; int nacks = 0; logic prev = 1'b0;
    read_req = 1'b1; address_bus = AW'($urandom);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && !prev) rises.push_back(k);
      if (rises.size() >= 2) read_req = 1'b0;
      if (mem_req === 1'b1 && nacks < 2) begin
        mem_ack = 1'b1; mem_rdata = (nacks == 0) ? 16'h0001 : 16'h0002; nacks++;
      end
      if (done === 1'b1) begin dts.push_back(k); rds.push_back(rdata); end
      prev = mem_req;
    end
    read_req = 1'b0; mem_ack = 1'b0; rdata_model = 16'h0002;
    checks++;
    if (rises.size() != 2 || rises[0] != 0 || rises[1] != 3) begin
      errors++; $display("FAIL b2b_spacing: %0d accesses, rises %p expected 0 and 3", rises.size(), rises);
    end
    checks++;
    if (dts.size() != 2 || rds[0] !== 16'h0001 || rds[1] !== 16'h0002 || dts[0] != 2 || dts[1] != 5) begin
      errors++; $display("FAIL b2b_rdata: dones %p rdata %p expected at 2,5 with 0001,0002", dts, rds);
    end
  endtask

  task automatic test_spurious_ack();
    logic bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'b1; mem_rdata = DW'($urandom);
      @(negedge clk);
      if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rdata !== rdata_model) bad = 1'b1;
    end
    mem_ack = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL spurious_ack: reaction=%b expected 0", bad); end
  endtask

  task automatic test_random();
    int rc, da, dw, wt; logic es, we, st, bo; logic [AW-1:0] a, addr; logic [DW-1:0] w, wd, rv; logic [1:0] sel;
    for (int i = 0; i < 24; i++) begin
      sel = 2'($urandom_range(1, 3)); addr = AW'($urandom); wd = DW'($urandom); rv = DW'($urandom);
`ifdef MEMSEQ_TIMEOUT_EN
      wt = $urandom_range(0, TO - 1);
`else
      wt = (i == 5) ? 20 : $urandom_range(0, 6);
`endif
      drive_txn(sel[0], sel[1], addr, wd, wt, rv, rc, da, dw, es, we, a, w, st, bo);
      if (sel == 2'b01) rdata_model = rv;
      checks++;
      if (we !== sel[1] || a !== addr || w !== wd || st !== 1'b1) begin
        errors++; $display("FAIL rnd_bus[%0d]: we=%b addr=%h data=%h stable=%b expected %b %h %h 1", i, we, a, w, st, sel[1], addr, wd);
      end
      checks++;
      if (rc != wt + 1 || da != wt + 2 || dw != 1) begin
        errors++; $display("FAIL rnd_timing[%0d]: req %0d done_at %0d width %0d expected %0d %0d 1", i, rc, da, dw, wt + 1, wt + 2);
      end
      checks++;
      if (rdata !== rdata_model || es !== 1'b0 || bo !== 1'b1) begin
        errors++; $display("FAIL rnd_result[%0d]: rdata=%h err=%b busy_ok=%b expected %h 0 1", i, rdata, es, bo, rdata_model);
      end
    end
  endtask

`ifdef MEMSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int rc, da, dw; logic es, we, st, bo; logic [AW-1:0] a; logic [DW-1:0] w;
    drive_txn(1'b1, 1'b0, 16'h0BAD, DW'($urandom), -1, DW'($urandom), rc, da, dw, es, we, a, w, st, bo);
    checks++; if (rc != TO || da != TO + 1) begin errors++; $display("FAIL to_abort: req %0d done_at %0d expected %0d %0d", rc, da, TO, TO + 1); end
    checks++; if (es !== 1'b1 || rdata !== rdata_model) begin errors++; $display("FAIL to_err: err=%b rdata=%h expected 1 %h", es, rdata, rdata_model); end
    drive_txn(1'b1, 1'b0, 16'h0BAD, DW'($urandom), TO - 1, 16'h4242, rc, da, dw, es, we, a, w, st, bo);
    rdata_model = 16'h4242;
    checks++; if (es !== 1'b0 || rdata !== rdata_model || da != TO + 1) begin errors++; $display("FAIL to_ack_wins: err=%b rdata=%h done_at=%0d expected 0 %h %0d", es, rdata, da, rdata_model, TO + 1); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_mid_access();
    test_zero_wait_read();
    test_waited_write();
    test_simultaneous();
    test_ignore_during_access();
    test_back_to_back();
    test_spurious_ack();
    test_random();
`ifdef MEMSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
